// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the 5-stage MIPS core write-back path.
//   - Opcode constants for the instruction subset the core implements.
//   - Write-back source encoding used by the MEM/WB decoder and data mux.
//   - Architectural register constants.
//   - op_is_legal(): true for every opcode the core understands.
// -----------------------------------------------------------------------------
package mips_pkg;

    // Primary opcodes (Instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Write-back data source
    typedef enum logic [1:0] {
        WB_SRC_ALU  = 2'd0,
        WB_SRC_MEM  = 2'd1,
        WB_SRC_LINK = 2'd2
    } wb_src_e;

    // Architectural registers
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    // True for every opcode the core decodes, whether or not it writes.
    function automatic logic op_is_legal(input logic [5:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI,
            OP_LW, OP_SW: legal = 1'b1;
            default:      legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/wb_decoder.sv
// -----------------------------------------------------------------------------
// wb_decoder
//   Combinational write-back decode for one instruction.
//   From the primary opcode and the rt/rd register fields it derives whether
//   the instruction writes the register file, which register it targets, where
//   the write-back data comes from, and whether the opcode is unknown.
//   The R-type funct field is deliberately not examined: every R-type writes.
// -----------------------------------------------------------------------------
module wb_decoder
    import mips_pkg::*;
#(
    parameter logic [4:0] LINK_REG = REG_RA
) (
    input  logic [5:0] op,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    output logic       writes,
    output logic [4:0] dest,
    output wb_src_e    src,
    output logic       illegal
);

    always_comb begin
        writes  = 1'b0;
        dest    = REG_ZERO;
        src     = WB_SRC_ALU;
        illegal = !op_is_legal(op);
        case (op)
            OP_RTYPE: begin
                writes = 1'b1;
                dest   = rd;
                src    = WB_SRC_ALU;
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
                writes = 1'b1;
                dest   = rt;
                src    = WB_SRC_ALU;
            end
            OP_LW: begin
                writes = 1'b1;
                dest   = rt;
                src    = WB_SRC_MEM;
            end
            OP_JAL: begin
                writes = 1'b1;
                dest   = LINK_REG;
                src    = WB_SRC_LINK;
            end
            default: begin
                // sw, branches, j and illegal opcodes leave the register file alone
                writes = 1'b0;
                dest   = REG_ZERO;
                src    = WB_SRC_ALU;
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//   MEM/WB pipeline register and write-back logic of the 5-stage MIPS core.
//   Latches the MEM-stage results, decodes the destination and data source
//   from the latched instruction and drives the register-file write port.
//   Also counts accepted valid instructions and flags unknown opcodes.
//   Ports:
//     ClockInput      in   1  pipeline clock (rising edge)
//     ResetInput      in   1  asynchronous active-high reset
//     InValid         in   1  MEM stage holds a real instruction
//     Stall           in   1  hold all latched state this edge
//     Flush           in   1  latch a bubble this edge (beats Stall)
//     Instruction     in  32  MEM-stage instruction
//     PCAddress       in  32  address of that instruction
//     ALUResult       in  32  ALU result / memory address
//     ReadData        in  32  data RAM read data
//     RegWriteEnable  out  1  register-file write strobe
//     WriteRegister   out  5  register-file write address
//     WriteBackData   out 32  register-file write data (also forwarding tap)
//     WBValid         out  1  latched slot holds a valid instruction
//     RetiredCount    out 32  number of valid instructions accepted (wraps)
//     IllegalSeen     out  1  sticky: an unknown opcode was accepted
//   All outputs depend only on latched state: one cycle of latency and no
//   combinational path from inputs to outputs.
// -----------------------------------------------------------------------------
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter logic [4:0]  LINK_REG    = REG_RA,
    parameter logic [31:0] LINK_OFFSET = 32'd4
) (
    input  logic        ClockInput,
    input  logic        ResetInput,
    input  logic        InValid,
    input  logic        Stall,
    input  logic        Flush,
    input  logic [31:0] Instruction,
    input  logic [31:0] PCAddress,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ReadData,
    output logic        RegWriteEnable,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteBackData,
    output logic        WBValid,
    output logic [31:0] RetiredCount,
    output logic        IllegalSeen
);

    logic [31:0] instr_p1;
    logic [31:0] pc_p1;
    logic [31:0] alu_p1;
    logic [31:0] rdata_p1;
    logic        vld_p1;
    logic [31:0] retired_cnt;
    logic        illegal_seen;

    logic        dec_writes;
    logic [4:0]  dec_dest;
    wb_src_e     dec_src;
    logic        dec_illegal;
    logic [31:0] wb_data;

    // Source-register and funct/shamt fields are not needed for write-back.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr_p1[25:21], instr_p1[10:0]};

    // ---- MEM -> WB boundary --------------------------------------------------
    always_ff @(posedge ClockInput or posedge ResetInput) begin
        if (ResetInput) begin
            instr_p1     <= '0;
            pc_p1        <= '0;
            alu_p1       <= '0;
            rdata_p1     <= '0;
            vld_p1       <= 1'b0;
            retired_cnt  <= '0;
            illegal_seen <= 1'b0;
        end else if (Flush) begin
            // Bubble: only the valid bit matters, data latches simply hold.
            vld_p1 <= 1'b0;
        end else if (!Stall) begin
            instr_p1 <= Instruction;
            pc_p1    <= PCAddress;
            alu_p1   <= ALUResult;
            rdata_p1 <= ReadData;
            vld_p1   <= InValid;
            if (InValid) begin
                retired_cnt <= retired_cnt + 32'd1;
                // The incoming opcode is checked so the flag rises together
                // with WBValid for the offending instruction.
                if (!op_is_legal(Instruction[31:26])) begin
                    illegal_seen <= 1'b1;
                end
            end
        end
    end

    // ---- WB stage: decode and drive the register-file port -------------------
    wb_decoder #(
        .LINK_REG (LINK_REG)
    ) u_wb_decoder (
        .op      (instr_p1[31:26]),
        .rt      (instr_p1[20:16]),
        .rd      (instr_p1[15:11]),
        .writes  (dec_writes),
        .dest    (dec_dest),
        .src     (dec_src),
        .illegal (dec_illegal)
    );

    always_comb begin
        wb_data = alu_p1;
        case (dec_src)
            WB_SRC_ALU:  wb_data = alu_p1;
            WB_SRC_MEM:  wb_data = rdata_p1;
            WB_SRC_LINK: wb_data = pc_p1 + LINK_OFFSET;
            default:     wb_data = alu_p1;
        endcase
    end

    // Illegal opcodes already decode as non-writing; gating on the flag too
    // keeps a future decoder edit from turning an unknown opcode into a write.
    assign RegWriteEnable = vld_p1 & dec_writes & ~dec_illegal & (dec_dest != REG_ZERO);
    assign WriteRegister  = vld_p1 ? dec_dest : REG_ZERO;
    assign WriteBackData  = vld_p1 ? wb_data : 32'd0;
    assign WBValid        = vld_p1;
    assign RetiredCount   = retired_cnt;
    assign IllegalSeen    = illegal_seen;

endmodule
